// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arith, bit-serial shifts, shift-add multiply.
// Operands and results each move on their own valid/ready handshake.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [4:0]       operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             equal,
  output logic             less,
  output logic             carry,
  output logic             zero,
  output logic             err
);

  localparam logic [4:0] OP_AND = 5'b00000;
  localparam logic [4:0] OP_OR  = 5'b00001;
  localparam logic [4:0] OP_NOT = 5'b00010;
  localparam logic [4:0] OP_XOR = 5'b00011;
  localparam logic [4:0] OP_ADD = 5'b00100;
  localparam logic [4:0] OP_SUB = 5'b00101;
  localparam logic [4:0] OP_PAR = 5'b00110;
  localparam logic [4:0] OP_MUL = 5'b00111;
  localparam logic [4:0] OP_LSL = 5'b10000;
  localparam logic [4:0] OP_LSR = 5'b10001;
  localparam logic [4:0] OP_ASR = 5'b10010;

  localparam int DW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);
  localparam logic [SHW-1:0]   W_CNT = SHW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       op_q, op_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [DW-1:0]    opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             equal_q, equal_d;
  logic             less_q, less_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  logic             accept;
  logic             is_mul;
  logic             is_shift;
  logic [SHW-1:0]   amt;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_err;
  logic [WIDTH-1:0] sh_cur;
  logic [WIDTH-1:0] sh_nx;
  logic [DW-1:0]    acc_nx;

  assign in_ready = (state_q == S_IDLE) && !reset;
  assign accept   = in_valid && in_ready;
  assign is_mul   = (operation == OP_MUL);
  assign is_shift = (operation == OP_LSL) ||
                    (operation == OP_LSR) ||
                    (operation == OP_ASR);

  // Shifting WIDTH times already yields the saturated result.
  assign amt = (in2 >= W_VAL) ? W_CNT : in2[SHW-1:0];
  assign sum = {1'b0, in1} + {1'b0, in2};
  assign dif = {1'b0, in1} - {1'b0, in2};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_err = 1'b0;
    unique case (operation)
      OP_AND: alu_res = in1 & in2;
      OP_OR:  alu_res = in1 | in2;
      OP_NOT: alu_res = ~in1;
      OP_XOR: alu_res = in1 ^ in2;
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
      end
      OP_SUB: begin
        alu_res = dif[WIDTH-1:0];
        alu_c   = dif[WIDTH];
      end
      OP_PAR: alu_res = WIDTH'(^in1);
      OP_MUL: alu_res = '0;
      OP_LSL, OP_LSR, OP_ASR: alu_res = in1;
      default: begin
        alu_res = '1;
        alu_err = 1'b1;
      end
    endcase
  end

  assign sh_cur = opa_q[WIDTH-1:0];
  assign acc_nx = opb_q[0] ? acc_q + opa_q : acc_q;

  always_comb begin
    sh_nx = sh_cur;
    unique case (op_q)
      OP_LSL:  sh_nx = {sh_cur[WIDTH-2:0], 1'b0};
      OP_LSR:  sh_nx = {1'b0, sh_cur[WIDTH-1:1]};
      OP_ASR:  sh_nx = {sh_cur[WIDTH-1], sh_cur[WIDTH-1:1]};
      default: sh_nx = sh_cur;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    out_d   = out_q;
    equal_d = equal_q;
    less_d  = less_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = operation;
          equal_d = (in1 == in2);
          less_d  = (in1 < in2);
          opa_d   = {{WIDTH{1'b0}}, in1};
          opb_d   = in2;
          acc_d   = '0;
          if (is_mul) begin
            cnt_d   = W_CNT;
            state_d = S_BUSY;
          end else if (is_shift && amt != '0) begin
            cnt_d   = amt;
            state_d = S_BUSY;
          end else begin
            state_d = S_DONE;
            out_d   = alu_res;
            carry_d = alu_c;
            err_d   = alu_err;
            zero_d  = (alu_res == '0);
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - SHW'(1);
        if (op_q == OP_MUL) begin
          acc_d = acc_nx;
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
        end else begin
          opa_d = {{WIDTH{1'b0}}, sh_nx};
        end
        // The last step lands directly in DONE with the finished result.
        if (cnt_q == SHW'(1)) begin
          state_d = S_DONE;
          err_d   = 1'b0;
          if (op_q == OP_MUL) begin
            out_d   = acc_nx[WIDTH-1:0];
            carry_d = |acc_nx[DW-1:WIDTH];
            zero_d  = (acc_nx[WIDTH-1:0] == '0);
          end else begin
            out_d   = sh_nx;
            carry_d = 1'b0;
            zero_d  = (sh_nx == '0);
          end
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      out_q   <= '0;
      equal_q <= 1'b0;
      less_q  <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      out_q   <= out_d;
      equal_q <= equal_d;
      less_q  <= less_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign out       = out_q;
  assign equal     = equal_q;
  assign less      = less_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed scenarios plus random ops against an
// arithmetic reference model, on WIDTH=8 and WIDTH=16 instances.
module tb_alu_seq;

  localparam logic [4:0] OP_AND = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00101;
  localparam logic [4:0] OP_ADD = 5'b00100;
  localparam logic [4:0] OP_OR  = 5'b00001;
  localparam logic [4:0] OP_NOT = 5'b00010;
  localparam logic [4:0] OP_XOR = 5'b00011;
  localparam logic [4:0] OP_PAR = 5'b00110;
  localparam logic [4:0] OP_MUL = 5'b00111;
  localparam logic [4:0] OP_LSL = 5'b10000;
  localparam logic [4:0] OP_LSR = 5'b10001;
  localparam logic [4:0] OP_ASR = 5'b10010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        v8 = 1'b0, rdy8, ov8, r8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, o8;
  logic [4:0]  op8 = '0;
  logic        eq8, ls8, c8, z8, e8;
  logic        v16 = 1'b0, rdy16, ov16, r16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, o16;
  logic [4:0]  op16 = '0;
  logic        eq16, ls16, c16, z16, e16;

  int n_cmp = 0;
  int n_bad = 0;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset),
    .in_valid(v8), .in_ready(rdy8),
    .in1(a8), .in2(b8), .operation(op8),
    .out_valid(ov8), .out_ready(r8), .out(o8),
    .equal(eq8), .less(ls8), .carry(c8), .zero(z8), .err(e8)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset),
    .in_valid(v16), .in_ready(rdy16),
    .in1(a16), .in2(b16), .operation(op16),
    .out_valid(ov16), .out_ready(r16), .out(o16),
    .equal(eq16), .less(ls16), .carry(c16), .zero(z16), .err(e16)
  );

  // Reference: flags packed as {carry, zero, err, equal, less}.
  function automatic void model(input int w, input logic [4:0] op,
                                input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic [4:0] fl,
                                output int lat);
    longint unsigned ua, ub, mask, res, p;
    longint s;
    int amt;
    logic c, e;
    mask = (64'd1 << w) - 64'd1;
    ua = a & mask;
    ub = b & mask;
    c = 1'b0;
    e = 1'b0;
    lat = 1;
    res = 0;
    amt = (ub > longint'(w)) ? w : int'(ub);
    case (op)
      OP_AND: res = ua & ub;
      OP_OR:  res = ua | ub;
      OP_NOT: res = ~ua & mask;
      OP_XOR: res = ua ^ ub;
      OP_ADD: begin res = (ua + ub) & mask; c = (ua + ub) > mask; end
      OP_SUB: begin res = (ua - ub) & mask; c = ua < ub; end
      OP_PAR: res = longint'($countones(ua) % 2);
      OP_MUL: begin
        p = ua * ub;
        res = p & mask;
        c = (p >> w) != 0;
        lat = w + 1;
      end
      OP_LSL: begin res = (ua << amt) & mask; lat = amt + 1; end
      OP_LSR: begin res = ua >> amt; lat = amt + 1; end
      OP_ASR: begin
        s = ((ua >> (w - 1)) != 0) ? longint'(ua) - longint'(64'd1 << w)
                                   : longint'(ua);
        s = s >>> amt;
        res = s & mask;
        lat = amt + 1;
      end
      default: begin res = mask; e = 1'b1; end
    endcase
    r = res[15:0];
    fl = {c, res == 0, e, ua == ub, ua < ub};
  endfunction

  // Drives one transaction; returns observed result, flags and latency.
  task automatic run(input bit w16, input logic [4:0] op,
                     input logic [15:0] a, input logic [15:0] b,
                     input bit hold, output logic [15:0] o,
                     output logic [4:0] fl, output int lat, output bit to);
    int k;
    to = 1'b0;
    @(negedge clk);
    if (w16) begin
      op16 = op; a16 = a; b16 = b; v16 = 1'b1; r16 = !hold;
    end else begin
      op8 = op; a8 = a[7:0]; b8 = b[7:0]; v8 = 1'b1; r8 = !hold;
    end
    k = 0;
    while (!(w16 ? rdy16 : rdy8) && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) to = 1'b1;
    @(posedge clk);
    #1;
    v8 = 1'b0;
    v16 = 1'b0;
    lat = 1;
    while (!(w16 ? ov16 : ov8) && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!(w16 ? ov16 : ov8)) to = 1'b1;
    o = w16 ? o16 : {8'h00, o8};
    fl = w16 ? {c16, z16, e16, eq16, ls16} : {c8, z8, e8, eq8, ls8};
    if (!hold) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({rdy8, ov8, o8, eq8, ls8, c8, z8, e8} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_hold rdy=%b ov=%b out=%h flags=%b need 0/0/00/00000",
               rdy8, ov8, o8, {c8, z8, e8, eq8, ls8});
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (rdy8 !== 1'b1 || ov8 !== 1'b0 || rdy16 !== 1'b1 || ov16 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release rdy8=%b ov8=%b rdy16=%b ov16=%b need 1 0 1 0",
               rdy8, ov8, rdy16, ov16);
    end
  endtask

  task automatic test_add(input bit w16);
    logic [15:0] o, a, ex;
    logic [4:0] fl;
    int lat;
    bit to;
    a = w16 ? 16'hFFF0 : 16'h00F0;
    ex = 16'h0010;
    run(w16, OP_ADD, a, 16'h0020, 1'b0, o, fl, lat, to);
    n_cmp++;
    if (to || o !== ex || fl !== 5'b10000 || lat != 1) begin
      n_bad++;
      $display("FAIL add w16=%b out=%h need %h flags=%b need 10000 lat=%0d need 1 to=%b",
               w16, o, ex, fl, lat, to);
    end
    n_cmp++;
    if ((w16 ? rdy16 : rdy8) !== 1'b1 || (w16 ? ov16 : ov8) !== 1'b0) begin
      n_bad++;
      $display("FAIL add_handoff w16=%b in_ready=%b out_valid=%b need 1 0",
               w16, w16 ? rdy16 : rdy8, w16 ? ov16 : ov8);
    end
  endtask

  task automatic test_sub();
    logic [15:0] o;
    logic [4:0] fl;
    int lat;
    bit to;
    run(1'b0, OP_SUB, 16'd5, 16'd5, 1'b0, o, fl, lat, to);
    n_cmp++;
    if (to || o !== 16'h0000 || fl !== 5'b01010 || lat != 1) begin
      n_bad++;
      $display("FAIL sub_eq out=%h need 00 flags=%b need 01010 lat=%0d to=%b",
               o, fl, lat, to);
    end
    run(1'b0, OP_SUB, 16'd3, 16'd7, 1'b0, o, fl, lat, to);
    n_cmp++;
    if (to || o !== 16'h00FC || fl !== 5'b10001 || lat != 1) begin
      n_bad++;
      $display("FAIL sub_borrow out=%h need fc flags=%b need 10001 lat=%0d to=%b",
               o, fl, lat, to);
    end
  endtask

  task automatic test_shift();
    logic [15:0] o;
    logic [4:0] fl;
    int lat;
    bit to;
    run(1'b0, OP_LSL, 16'h0081, 16'd3, 1'b0, o, fl, lat, to);
    n_cmp++;
    if (to || o !== 16'h0008 || fl !== 5'b00000 || lat != 4) begin
      n_bad++;
      $display("FAIL lsl3 out=%h need 08 flags=%b need 00000 lat=%0d need 4 to=%b",
               o, fl, lat, to);
    end
    run(1'b0, OP_ASR, 16'h0080, 16'd200, 1'b0, o, fl, lat, to);
    n_cmp++;
    if (to || o !== 16'h00FF || fl !== 5'b00001 || lat != 9) begin
      n_bad++;
      $display("FAIL asr_sat out=%h need ff flags=%b need 00001 lat=%0d need 9 to=%b",
               o, fl, lat, to);
    end
    run(1'b0, OP_LSR, 16'h005A, 16'd0, 1'b0, o, fl, lat, to);
    n_cmp++;
    if (to || o !== 16'h005A || fl !== 5'b00000 || lat != 1) begin
      n_bad++;
      $display("FAIL lsr0 out=%h need 5a flags=%b need 00000 lat=%0d need 1 to=%b",
               o, fl, lat, to);
    end
  endtask

  task automatic test_mul(input bit w16);
    logic [15:0] o, a, b;
    logic [4:0] fl;
    int lat, el;
    bit to;
    el = w16 ? 17 : 9;
    a = w16 ? 16'h00FF : 16'h000F;
    b = w16 ? 16'h0101 : 16'h0011;
    run(w16, OP_MUL, a, b, 1'b0, o, fl, lat, to);
    n_cmp++;
    if (to || o !== (w16 ? 16'hFFFF : 16'h00FF) || fl !== 5'b00001 || lat != el) begin
      n_bad++;
      $display("FAIL mul_full w16=%b out=%h flags=%b need 00001 lat=%0d need %0d to=%b",
               w16, o, fl, lat, el, to);
    end
    a = w16 ? 16'h0100 : 16'h0010;
    run(w16, OP_MUL, a, a, 1'b0, o, fl, lat, to);
    n_cmp++;
    if (to || o !== 16'h0000 || fl !== 5'b11010 || lat != el) begin
      n_bad++;
      $display("FAIL mul_ovf w16=%b out=%h need 0 flags=%b need 11010 lat=%0d need %0d to=%b",
               w16, o, fl, lat, el, to);
    end
  endtask

  task automatic test_illegal_hold();
    logic [15:0] o;
    logic [4:0] fl;
    int lat;
    bit to;
    run(1'b0, 5'b01111, 16'h0012, 16'h0034, 1'b1, o, fl, lat, to);
    n_cmp++;
    if (to || o !== 16'h00FF || fl !== 5'b00101 || lat != 1) begin
      n_bad++;
      $display("FAIL illegal out=%h need ff flags=%b need 00101 lat=%0d need 1 to=%b",
               o, fl, lat, to);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      v8 = 1'b1;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      op8 = OP_ADD;
      @(posedge clk);
      #1;
      n_cmp++;
      if (ov8 !== 1'b1 || rdy8 !== 1'b0 || o8 !== 8'hFF ||
          {c8, z8, e8, eq8, ls8} !== 5'b00101) begin
        n_bad++;
        $display("FAIL hold%0d ov=%b rdy=%b out=%h flags=%b need 1 0 ff 00101",
                 i, ov8, rdy8, o8, {c8, z8, e8, eq8, ls8});
      end
    end
    @(negedge clk);
    v8 = 1'b0;
    r8 = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (ov8 !== 1'b0 || rdy8 !== 1'b1) begin
      n_bad++;
      $display("FAIL hold_release ov=%b rdy=%b need 0 1", ov8, rdy8);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (ov8 !== 1'b0 || rdy8 !== 1'b1 || o8 !== 8'hFF || {eq8, ls8} !== 2'b01) begin
      n_bad++;
      $display("FAIL no_stray_accept ov=%b rdy=%b out=%h eq/ls=%b need 0 1 ff 01",
               ov8, rdy8, o8, {eq8, ls8});
    end
  endtask

  task automatic test_reset_mid_mul();
    logic [15:0] o;
    logic [4:0] fl;
    int lat, k;
    bit to, seen;
    @(negedge clk);
    op8 = OP_MUL; a8 = 8'h03; b8 = 8'h05; v8 = 1'b1; r8 = 1'b1;
    k = 0;
    while (!rdy8 && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    v8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (ov8 !== 1'b0 || rdy8 !== 1'b0 || ls8 !== 1'b1) begin
      n_bad++;
      $display("FAIL mul_busy ov=%b rdy=%b less=%b need 0 0 1", ov8, rdy8, ls8);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({ov8, o8, eq8, ls8, c8, z8, e8} !== 14'd0) begin
      n_bad++;
      $display("FAIL reset_abort ov=%b out=%h flags=%b need 0 00 00000",
               ov8, o8, {c8, z8, e8, eq8, ls8});
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (ov8) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL abort_no_result out_valid=1 need 0");
    end
    run(1'b0, OP_AND, 16'h00AA, 16'h000F, 1'b0, o, fl, lat, to);
    n_cmp++;
    if (to || o !== 16'h000A || fl !== 5'b00000 || lat != 1) begin
      n_bad++;
      $display("FAIL and_after_reset out=%h need 0a flags=%b need 00000 lat=%0d to=%b",
               o, fl, lat, to);
    end
  endtask

  task automatic test_random(input bit w16, input int n);
    logic [15:0] a, b, o, er;
    logic [4:0] op, fl, ef;
    int sel, w, lat, el;
    bit to;
    w = w16 ? 16 : 8;
    for (int i = 0; i < n; i++) begin
      sel = $urandom_range(0, 13);
      if (sel < 8) begin
        op = 5'(sel);
      end else if (sel < 11) begin
        op = 5'(16 + sel - 8);
      end else begin
        op = 5'($urandom);
        while (op inside {[5'd0:5'd7], 5'd16, 5'd17, 5'd18}) op = 5'($urandom);
      end
      a = 16'($urandom);
      b = 16'($urandom);
      if (!w16) begin
        a = a & 16'h00FF;
        b = b & 16'h00FF;
      end
      if (sel >= 8 && sel < 11 && $urandom_range(0, 1) == 1)
        b = 16'($urandom_range(0, w + 2));
      if ($urandom_range(0, 7) == 0) b = a;
      model(w, op, a, b, er, ef, el);
      run(w16, op, a, b, 1'b0, o, fl, lat, to);
      n_cmp++;
      if (to || o !== er || fl !== ef || lat != el) begin
        n_bad++;
        $display("FAIL rand w=%0d op=%b a=%h b=%h out=%h need %h flags=%b need %b lat=%0d need %0d to=%b",
                 w, op, a, b, o, er, fl, ef, lat, el, to);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add(1'b0);
    test_sub();
    test_shift();
    test_mul(1'b0);
    test_illegal_hold();
    test_reset_mid_mul();
    test_random(1'b0, 150);
    test_add(1'b1);
    test_mul(1'b1);
    test_random(1'b1, 40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
